// File: rtl/freq_dec_pkg.sv
// rtl/freq_dec_pkg.sv - shared types and constants for the period decoder
package freq_dec_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Number of periods folded into the running average
  localparam int AVG_DEPTH = 4;

  // All-ones value of a cnt_w-bit counter, i.e. the saturation point
  function automatic logic [63:0] sat_value(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - async pulse synchroniser with registered rising-edge strobe
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // Shift the async input through the synchroniser, keep the previous level, register the rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/freq_period_decoder.sv
// rtl/freq_period_decoder.sv - pulse period measurement with valid/ready output; FREQ_DEC_AVG_EN adds 4-deep averaging
module freq_period_decoder
  import freq_dec_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun,
  output logic             glitch
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             glitch_q, glitch_d;

  logic             pulse_rise;
  logic             unused_pulse_lvl;
  logic             capture;
  logic             emit;
  logic [CNT_W-1:0] emit_val;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(pulse_in),
    .level_o(unused_pulse_lvl),
    .rise_o (pulse_rise)
  );

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      glitch_q  <= glitch_d;
    end
  end

  // Measurement FSM: arm on enable, count between rises, saturate into timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    timeout_d = 1'b0;
    glitch_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (pulse_rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // An accepted rise beats saturation, so a full-scale period is still reported
        if (pulse_rise && (cnt_q >= MIN_CNT)) begin
          capture = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          glitch_d = pulse_rise;
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ARMED;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      capture   = 1'b0;
      timeout_d = 1'b0;
      glitch_d  = 1'b0;
    end
  end

`ifdef FREQ_DEC_AVG_EN
  localparam int SUM_W = CNT_W + 2;

  logic [CNT_W-1:0] hist_q [AVG_DEPTH];
  logic [CNT_W-1:0] hist_d [AVG_DEPTH];
  logic [SUM_W-1:0] sum_q, sum_d, sum_next;
  logic [1:0]       fill_q, fill_d;
  logic             hist_clr;

  // History registers for the running average
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end

  // Slide the window on each capture; emit the mean only once the window is full
  always_comb begin
    hist_d   = hist_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    emit     = 1'b0;
    emit_val = '0;
    hist_clr = ((state_q == ST_IDLE) && enable) || timeout_d || glitch_d;
    sum_next = sum_q + SUM_W'(cnt_q) - SUM_W'(hist_q[AVG_DEPTH-1]);
    if (hist_clr) begin
      for (int i = 0; i < AVG_DEPTH; i++) hist_d[i] = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (capture) begin
      hist_d[0] = cnt_q;
      for (int i = 1; i < AVG_DEPTH; i++) hist_d[i] = hist_q[i-1];
      sum_d = sum_next;
      if (fill_q == 2'(AVG_DEPTH - 1)) begin
        emit     = 1'b1;
        emit_val = sum_next[SUM_W-1:2];
      end else begin
        fill_d = fill_q + 2'd1;
      end
    end
  end
`else
  // Every accepted capture goes straight to the output
  always_comb begin
    emit     = capture;
    emit_val = cnt_q;
  end
`endif

  // Output handshake: hold until accepted, overwrite and flag overrun when not drained
  always_comb begin
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && period_ready) valid_d = 1'b0;
    if (emit) begin
      period_d = emit_val;
      valid_d  = 1'b1;
      if (valid_q && !period_ready) overrun_d = 1'b1;
    end
    if (!enable) overrun_d = 1'b0;
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;
  assign glitch       = glitch_q;

endmodule
